// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   XLEN            datapath width (only 32 is supported)
//   F3_*            funct3 encodings of the eight RV32M operations
//   state_e         sequencer states (IDLE / RUN / DONE)
//   DIV_BY_ZERO_Q   quotient returned for a zero divisor
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/rv32m_div_core.sv
// One restoring-division iteration on unsigned magnitudes.
// Shifts the next dividend bit (MSB of quo_i) into the partial remainder,
// trial-subtracts the divisor and inserts the resulting quotient bit.
//   rem_i / rem_o       partial remainder before / after the step
//   quo_i / quo_o       dividend-shifting quotient register before / after
//   divisor_i           divisor magnitude
// Only instantiated when RV32M_DIV_EN is defined.
module rv32m_div_core
  import rv32m_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor_i};

  // Since rem_i < divisor, a set MSB of diff means the trial subtract borrowed.
  always_comb begin
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide
// iterations on operand magnitudes, sign fix-up at the end, fixed 33-cycle
// latency from acceptance to the one-cycle done pulse.
// Ports:
//   clk, reset (async, active-low)
//   start, funct3, op_a, op_b, rd_in   request (sampled only in IDLE)
//   busy                               operation in flight (core stall)
//   done, result, rd_out, we_out       writeback, valid while done=1
//   illegal                            divide op in a build without divider
// Build option: define RV32M_DIV_EN to build the divider; otherwise funct3
// 4..7 run the full sequence and complete with illegal=1, result=0, we_out=0.
module rv32m_muldiv_unit
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out,
  output logic            illegal
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q;
  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   mcand_q, hi_q, lo_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [4:0]        rd_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, div_res, fin_res, res_q;
  logic [4:0]        rd_out_q;
  logic              op_illegal;

  assign accept = (state_q == IDLE) && start;

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               cnt_q <= '0;
    else if (accept)          cnt_q <= '0;
    else if (state_q == RUN)  cnt_q <= cnt_q + 5'd1;
  end

  // Operand magnitudes: only the signed flavours negate a set MSB.
  always_comb begin
    a_neg = op_a[XLEN-1] && (funct3 == F3_MULH || funct3 == F3_MULHSU ||
                             funct3 == F3_DIV  || funct3 == F3_REM);
    b_neg = op_b[XLEN-1] && (funct3 == F3_MULH || funct3 == F3_DIV ||
                             funct3 == F3_REM);
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

  // Shift-add multiply step on {hi, lo}; lo starts as the multiplier.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

`ifdef RV32M_DIV_EN
  logic            rneg_q, bzero_q;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] div_rem, div_quo, quo_fix, rem_fix;

  // For divides, hi holds the remainder and lo the dividend/quotient.
  rv32m_div_core u_div_core (
    .rem_i     (hi_q),
    .quo_i     (lo_q),
    .divisor_i (mcand_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      rneg_q  <= a_neg;
      bzero_q <= (op_b == '0);
      opa_q   <= op_a;
    end
  end

  always_comb begin
    step_hi = f3_q[2] ? div_rem : mul_sum[XLEN:1];
    step_lo = f3_q[2] ? div_quo : {mul_sum[0], lo_q[XLEN-1:1]};
    quo_fix = neg_q  ? -lo_q : lo_q;
    rem_fix = rneg_q ? -hi_q : hi_q;
    if (bzero_q) begin
      quo_fix = DIV_BY_ZERO_Q;
      rem_fix = opa_q;
    end
    div_res    = f3_q[1] ? rem_fix : quo_fix;
    op_illegal = 1'b0;
  end
`else
  always_comb begin
    step_hi    = mul_sum[XLEN:1];
    step_lo    = {mul_sum[0], lo_q[XLEN-1:1]};
    div_res    = '0;
    op_illegal = f3_q[2];
  end
`endif

  // Operand latch and iteration registers (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q  <= funct3;
      rd_q  <= rd_in;
      neg_q <= a_neg ^ b_neg;
      hi_q  <= '0;
      if (funct3[2]) begin
        mcand_q <= b_mag;
        lo_q    <= a_mag;
      end else begin
        mcand_q <= a_mag;
        lo_q    <= b_mag;
      end
    end else if (state_q == RUN) begin
      hi_q <= step_hi;
      lo_q <= step_lo;
    end
  end

  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = neg_q ? -prod : prod;
    mul_res = (f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    fin_res = f3_q[2] ? div_res : mul_res;
  end

  // Writeback hold registers: keep the last result/rd visible after done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q    <= '0;
      rd_out_q <= '0;
    end else if (state_q == DONE) begin
      res_q    <= fin_res;
      rd_out_q <= rd_q;
    end
  end

  assign result  = done ? fin_res : res_q;
  assign rd_out  = done ? rd_q : rd_out_q;
  assign illegal = done && op_illegal;
  assign we_out  = done && (rd_q != 5'd0) && !op_illegal;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
module tb_rv32m_muldiv_unit;

  logic        clk, reset, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, we_out, illegal;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_err = 0;

  rv32m_muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .we_out  (we_out),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op, scramble the inputs right after acceptance, wait (bounded)
  // for done and return what the DUT shows then and one cycle later.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                       output logic we, output logic ill, output int lat,
                       output logic done_n, output logic busy_n);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    funct3 = 3'($urandom); rd_in = 5'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    res = result; rdo = rd_out; we = we_out; ill = illegal;
    @(negedge clk);
    done_n = done; busy_n = busy;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (we_out !== 1'b0)  begin n_err++; $display("FAIL reset_we got=%b exp=0", we_out); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result); end
    n_cmp++; if (rd_out !== 5'd0)  begin n_err++; $display("FAIL reset_rd got=%0d exp=0", rd_out); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  f[4]   = '{3'd0, 3'd3, 3'd1, 3'd2};
    logic [31:0] a[4]   = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b[4]   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
    logic [31:0] exp[4] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] res; logic [4:0] rdo; logic we, ill, dn, bn; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], 5'd5, res, rdo, we, ill, lat, dn, bn);
      n_cmp++; if (res !== exp[i]) begin n_err++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      n_cmp++; if (lat !== 33)     begin n_err++; $display("FAIL mul_latency[%0d] got=%0d exp=33", i, lat); end
      n_cmp++; if (rdo !== 5'd5 || we !== 1'b1 || ill !== 1'b0)
        begin n_err++; $display("FAIL mul_wb[%0d] got rd=%0d we=%b ill=%b exp rd=5 we=1 ill=0", i, rdo, we, ill); end
      n_cmp++; if (dn !== 1'b0 || bn !== 1'b0)
        begin n_err++; $display("FAIL mul_release[%0d] got done=%b busy=%b exp 0/0", i, dn, bn); end
      n_cmp++; if (result !== exp[i]) begin n_err++; $display("FAIL mul_hold[%0d] got=%h exp=%h", i, result, exp[i]); end
    end
  endtask

  task automatic test_div();
`ifdef RV32M_DIV_EN
    logic [2:0]  f[9]   = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7};
    logic [31:0] a[9]   = '{32'd20, 32'd20, 32'h80000000, 32'h80000000, 32'hFFFFFFF9,
                            32'hFFFFFFF9, 32'd9, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] b[9]   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                            32'd2, 32'd3, 32'd2, 32'd2};
    logic [31:0] exp[9] = '{32'hFFFFFFFF, 32'd20, 32'h80000000, 32'd0, 32'hFFFFFFFD,
                            32'hFFFFFFFF, 32'd3, 32'h7FFFFFFC, 32'd1};
    logic [31:0] res; logic [4:0] rdo; logic we, ill, dn, bn; int lat;
    for (int i = 0; i < 9; i++) begin
      do_op(f[i], a[i], b[i], 5'd12, res, rdo, we, ill, lat, dn, bn);
      n_cmp++; if (res !== exp[i]) begin n_err++; $display("FAIL div_result[%0d] got=%h exp=%h", i, res, exp[i]); end
      n_cmp++; if (lat !== 33)     begin n_err++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
      n_cmp++; if (we !== 1'b1 || ill !== 1'b0)
        begin n_err++; $display("FAIL div_wb[%0d] got we=%b ill=%b exp we=1 ill=0", i, we, ill); end
    end
`else
    logic [2:0]  f[2] = '{3'd5, 3'd6};
    logic [31:0] res; logic [4:0] rdo; logic we, ill, dn, bn; int lat;
    for (int i = 0; i < 2; i++) begin
      do_op(f[i], 32'd9, 32'd3, 5'd12, res, rdo, we, ill, lat, dn, bn);
      n_cmp++; if (res !== 32'h0) begin n_err++; $display("FAIL nodiv_result[%0d] got=%h exp=0", i, res); end
      n_cmp++; if (lat !== 33)    begin n_err++; $display("FAIL nodiv_latency[%0d] got=%0d exp=33", i, lat); end
      n_cmp++; if (we !== 1'b0 || ill !== 1'b1)
        begin n_err++; $display("FAIL nodiv_flags[%0d] got we=%b ill=%b exp we=0 ill=1", i, we, ill); end
      n_cmp++; if (dn !== 1'b0) begin n_err++; $display("FAIL nodiv_release[%0d] got done=%b exp 0", i, dn); end
    end
`endif
  endtask

  task automatic test_rd_zero();
    logic [31:0] res; logic [4:0] rdo; logic we, ill, dn, bn; int lat;
    do_op(3'd0, 32'd3, 32'd4, 5'd0, res, rdo, we, ill, lat, dn, bn);
    n_cmp++; if (lat !== 33)     begin n_err++; $display("FAIL rd0_latency got=%0d exp=33", lat); end
    n_cmp++; if (we !== 1'b0)    begin n_err++; $display("FAIL rd0_we got=%b exp=0", we); end
    n_cmp++; if (res !== 32'd12) begin n_err++; $display("FAIL rd0_result got=%h exp=c", res); end
  endtask

  task automatic test_back_to_back();
    int first, second, seen;
    first = -1; second = -1; seen = 0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd7;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (done) begin
        seen++;
        n_cmp++; if (result !== 32'd6 || we_out !== 1'b1)
          begin n_err++; $display("FAIL b2b_result got=%h we=%b exp=6 we=1", result, we_out); end
        if (seen == 1) first = i;
        else begin second = i; start = 1'b0; break; end
      end
    end
    n_cmp++; if (first !== 33)          begin n_err++; $display("FAIL b2b_first got=%0d exp=33", first); end
    n_cmp++; if (second - first !== 34) begin n_err++; $display("FAIL b2b_gap got=%0d exp=34", second - first); end
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] rdo; logic we, ill, dn, bn; int lat; int stray;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd100; op_b = 32'd100; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || we_out !== 1'b0)
      begin n_err++; $display("FAIL midrst_outputs got busy=%b done=%b we=%b exp 0/0/0", busy, done, we_out); end
    @(negedge clk);
    reset = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || we_out || busy) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL midrst_stray got=%0d exp=0", stray); end
    do_op(3'd0, 32'd3, 32'd4, 5'd9, res, rdo, we, ill, lat, dn, bn);
    n_cmp++; if (res !== 32'd12 || rdo !== 5'd9 || we !== 1'b1)
      begin n_err++; $display("FAIL midrst_next got res=%h rd=%0d we=%b exp c/9/1", res, rdo, we); end
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL midrst_latency got=%0d exp=33", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32m_muldiv_unit.md
# rv32m_muldiv_unit

Iterative RV32M multiply/divide execution unit for the RV32I core. Consumes the two source operands read from the register file (rdout1/rdout2), runs a fixed-latency shift-add / restoring-divide sequence, and returns a 32-bit result with a destination index and write enable that drive the register file write port (wrs3/rd/we). Holds the core stalled via `busy` while an operation is in flight.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  in  32  rs1 value (from rdout1).
- op_b  in  32  rs2 value (from rdout2).
- rd_in  in  5  destination register index.
- busy  out  1  operation in flight; the core stalls.
- done  out  1  one-cycle pulse; result, rd_out and we_out valid.
- result  out  32  to regfile wrs3.
- rd_out  out  5  to regfile rd.
- we_out  out  1  to regfile we; equals done && (rd_out != 0).
- illegal  out  1  valid with done; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: when start=1, latch op_a, op_b, funct3 and rd_in, clear counter, go to RUN. When start=0, stay in IDLE.
- RUN: one iteration per cycle over a 5-bit counter (0..31). When the counter reaches 31, go to DONE.
- DONE: drive done=1 and we_out. Go to IDLE on the next edge.
- Signed ops: operate on magnitudes and fix the sign at the end.
  - MULH: both operands are signed.
  - MULHSU: op_a is signed, op_b is unsigned.
  - DIV/REM: quotient sign is sign(a)^sign(b); remainder takes the sign of the dividend.
- Multiply: 64-bit product. MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = op_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Special cases use the same latency. No early-out.
- start while busy is ignored. Latched operands are immune to input changes after acceptance.
- rd_in = 0: the operation executes, done pulses and we_out stays 0.

## Timing
- Start accepted at edge E0. busy=1 from E0 until E33.
- done=1 for exactly the cycle between E32 and E33. busy is still 1 in that cycle, so the core writes back and releases the stall together.
- Fixed latency of 33 cycles from acceptance to done. Throughput is one op per 34 cycles. A new start is accepted no earlier than the cycle after E33.
- result and rd_out hold their last value until the next done. They are only meaningful while done=1.
- Reset values: busy=0, done=0, we_out=0, illegal=0, result=0, rd_out=0. State = IDLE.
- Reset asserted mid-operation aborts immediately: no done and no write. The first start after deassertion is accepted normally.

## Configuration
- Macro: `RV32M_DIV_EN`.
- Defined: funct3 4–7 execute as specified above; illegal is always 0.
- Undefined: no divider hardware is built. funct3 4–7 still take the full 33-cycle sequence. At done they return result=0, we_out=0 and illegal=1, so the core raises an illegal-instruction trap.
- Multiply ops are identical in both builds.

## Structure
- Package `rv32m_pkg`:
  - XLEN
  - funct3 localparams (`F3_MUL` … `F3_REMU`)
  - state enum (IDLE/RUN/DONE)
  - DIV_BY_ZERO_Q constant
- Sub-module `rv32m_div_core`: restoring-divider iteration (shift, trial subtract, quotient-bit insert). It is instantiated only under `RV32M_DIV_EN`.
- Multiply iteration, sign handling and the FSM live in the top module.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5 -> done 33 cycles later; result=0xFFFFFFEB, rd_out=5, we_out=1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result=0xFFFFFFFE. MULH with the same operands -> 0x00000000.
- DIV 20/0 -> 0xFFFFFFFF. REMU 20/0 -> 20. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1).
- Fixed latency and throughput:
  - start held high continuously -> exactly one op per 34 cycles.
  - operand changes after acceptance have no effect.
  - rd_in=0 -> done=1 with we_out=0.
- Reset during RUN (cycle 10) -> busy, done and we_out go to 0 immediately with no write. A following MUL 3×4 returns 12.
- Build without `RV32M_DIV_EN`: DIVU 9/3 -> done after 33 cycles with illegal=1, we_out=0, result=0.
